ntt_mux_pipe: RTL and testbench
===============================

Name: ntt_mux_pipe

Overview:
Parametrised, registered N:1 operand selector for the NTT datapath. Generalises the fixed 7-input 16-bit combinational mux: width and input count are parameters, the output is registered behind a valid/ready handshake, and a sequence mode steps the select automatically through all inputs. It sits between the coefficient/twiddle sources and the butterfly units.

Parameters:
WIDTH, 16, data width of each input and the output (Kyber coefficients use 16)
N_IN, 7, number of selectable inputs, at least 2
SEL_W, $clog2(N_IN), select width, derived and not overridden

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_flat  input  N_IN*WIDTH  packed inputs; input i is in_flat[i*WIDTH +: WIDTH]
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat
mode  input  1  0 = direct (use sel), 1 = sequence (use internal counter)
sel  input  SEL_W  direct-mode select
seq_start  input  1  restarts the sequence counter at 0
out_data  output  WIDTH  registered selected word
out_idx  output  SEL_W  index that produced out_data
out_last  output  1  sequence-mode beat with index N_IN-1
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts

Behaviour:
- Reset is asynchronous and active-low. While rst_n is low: out_data=0, out_idx=0, out_last=0, out_valid=0, seq_cnt=0, sel_err=0. Reset mid-transfer drops the held beat.
- in_ready = !out_valid || out_ready. This is combinational and gives a single-stage pipeline with no bubble at full throughput.
- Accept = in_valid && in_ready. Latency is 1 cycle: the beat accepted at edge k appears on out_* after edge k.
- On accept, idx = (mode ? seq_cnt_eff : sel). Then:
  - out_data = input[idx], or 0 if idx >= N_IN.
  - out_idx = idx.
  - out_last = mode && (idx == N_IN-1).
  - out_valid = 1.
- On no accept with out_ready high: out_valid clears to 0. out_data, out_idx and out_last hold their values.
- While out_valid && !out_ready, all out_* signals hold stable, and in_valid must not cause any change.
- Sequence counter seq_cnt:
  - seq_cnt_eff = seq_start ? 0 : seq_cnt.
  - On a sequence-mode accept: seq_cnt <= (seq_cnt_eff == N_IN-1) ? 0 : seq_cnt_eff+1.
  - seq_start with no accept: seq_cnt <= 0.
  - seq_start and accept in the same cycle: the beat uses index 0 and seq_cnt becomes 1.
  - In direct mode seq_cnt holds, except that seq_start still clears it.
- mode is sampled per accepted beat. Direct and sequence beats may interleave; direct beats do not advance seq_cnt.
- Direct sel >= N_IN (possible when N_IN is not a power of 2) gives out_data=0, never X.

Optional Feature:
NTT_MUX_SEL_ERR_EN
- With the macro defined: extra output sel_err (1 bit). It goes sticky high on the edge that accepts a direct-mode beat with sel >= N_IN. It is cleared only by reset or by seq_start.
- Without the macro: no sel_err port and no error register. Out-of-range select still yields 0.

Decomposition:
- Package ntt_mux_pkg holds:
  - typedef mux_mode_e: MUX_DIRECT=1'b0, MUX_SEQ=1'b1.
  - localparam NTT_COEFF_W=16.
  - function for the wrap increment, clog2-safe.
- Sub-module ntt_mux_comb (WIDTH, N_IN): purely combinational indexed select that returns 0 when out of range. The top level registers its output and owns the handshake and the counter.

Test Plan:
1. Direct mode, WIDTH=16, N_IN=7, inputs i -> 16'h0100+i, out_ready=1, sel=3 then 6 on back-to-back beats -> out_data 16'h0103 then 16'h0106, one beat per cycle, 1-cycle latency, out_last=0.
2. Sequence mode, seq_start pulsed with the first beat, 9 consecutive beats -> out_idx 0,1,2,3,4,5,6,0,1; out_last=1 only on idx 6; data matches 16'h0100+idx.
3. Backpressure: out_ready=0 for 4 cycles with in_valid=1 in sequence mode -> in_ready=0, out_* frozen, seq_cnt does not advance; the next index resumes correctly after out_ready=1.
4. seq_start while a beat is accepted at seq_cnt=4 -> that beat uses idx 0, the next beat uses idx 1; seq_start alone while idle -> the next sequence beat uses idx 0.
5. Direct sel=7 with N_IN=7 -> out_data=0, out_idx=7; with NTT_MUX_SEL_ERR_EN, sel_err rises and stays high until seq_start.
6. Assert rst_n low asynchronously while out_valid=1, mid-sequence -> out_valid, out_data and counter go to 0 immediately; the first post-reset sequence beat uses idx 0.

Source files
------------

// File: rtl/ntt_mux_pkg.sv
// Shared types and helpers for the NTT operand selector.
package ntt_mux_pkg;

  localparam int unsigned NTT_COEFF_W = 16;

  typedef enum logic {
    MUX_DIRECT = 1'b0,
    MUX_SEQ    = 1'b1
  } mux_mode_e;

  // Next sequence index, wrapping to 0 after n-1; safe for any n >= 1.
  function automatic int unsigned wrap_inc(input int unsigned cur, input int unsigned n);
    return (n == 0 || cur >= n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/ntt_mux_comb.sv
// Combinational N:1 indexed select; an out-of-range index yields zero.
module ntt_mux_comb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_IN  = 7,
  parameter int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data_c
);

  always_comb begin
    data_c = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (sel == SEL_W'(i)) data_c = in_flat[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/ntt_mux_pipe.sv
// Registered N:1 operand selector with valid/ready handshake and auto-sequencing.
// Optional sticky out-of-range select flag: define NTT_MUX_SEL_ERR_EN.
module ntt_mux_pipe
  import ntt_mux_pkg::*;
#(
  parameter int unsigned WIDTH = NTT_COEFF_W,
  parameter int unsigned N_IN  = 7,
  parameter int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_flat,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  seq_start,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  out_valid,
`ifdef NTT_MUX_SEL_ERR_EN
  output logic                  sel_err,
`endif
  input  logic                  out_ready
);

  logic [SEL_W-1:0] r_seq_cnt;
  logic             w_accept;
  mux_mode_e        w_mode;
  logic [SEL_W-1:0] w_cnt_eff;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_data;
  logic             w_last;

  // Single-stage pipe: the output register may be reloaded in the same cycle it drains.
  assign in_ready   = !out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_mode     = mux_mode_e'(mode);
  assign w_cnt_eff  = seq_start ? '0 : r_seq_cnt;
  assign w_idx      = (w_mode == MUX_SEQ) ? w_cnt_eff : sel;
  assign w_cnt_next = SEL_W'(wrap_inc(32'(w_cnt_eff), N_IN));
  assign w_last     = (w_mode == MUX_SEQ) && (w_idx == SEL_W'(N_IN - 1));

  ntt_mux_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_comb (
    .in_flat (in_flat),
    .sel     (w_idx),
    .data_c  (w_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_data  <= w_data;
      out_idx   <= w_idx;
      out_last  <= w_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Direct beats leave the counter alone; seq_start always rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_cnt <= '0;
    end else if (w_accept && (w_mode == MUX_SEQ)) begin
      r_seq_cnt <= w_cnt_next;
    end else if (seq_start) begin
      r_seq_cnt <= '0;
    end
  end

`ifdef NTT_MUX_SEL_ERR_EN
  logic w_sel_bad;
  assign w_sel_bad = w_accept && (w_mode == MUX_DIRECT)
                   && ({1'b0, sel} >= (SEL_W + 1)'(N_IN));

  // A new out-of-range accept takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (w_sel_bad) begin
      sel_err <= 1'b1;
    end else if (seq_start) begin
      sel_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_mux_pipe.sv
// Directed self-checking bench for ntt_mux_pipe (WIDTH=16, N_IN=7).
module tb_ntt_mux_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N_IN  = 7;
  localparam int unsigned SEL_W = 3;

  logic                  clk;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] in_flat;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic                  seq_start;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_idx;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
`ifdef NTT_MUX_SEL_ERR_EN
  logic                  sel_err;
`endif

  int n_total = 0;
  int n_bad   = 0;

  ntt_mux_pipe #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flat   (in_flat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .seq_start (seq_start),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
`ifdef NTT_MUX_SEL_ERR_EN
    .sel_err   (sel_err),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_idx"},   32'(out_idx),   32'(idx));
    chk({tag, "_data"},  32'(out_data),  (idx < int'(N_IN)) ? 32'h0100 + 32'(idx) : 32'd0);
    chk({tag, "_last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    for (int i = 0; i < int'(N_IN); i++) in_flat[i*WIDTH +: WIDTH] = 16'h0100 + 16'(i);
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; sel = '0; seq_start = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    step();

    // Direct back-to-back beats
    in_valid = 1'b1; mode = 1'b0; sel = 3'd3;
    step();
    chk_beat("dir3", 3, 1'b0);
    sel = 3'd6;
    step();
    chk_beat("dir6", 6, 1'b0);
    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold",  32'(out_data),  32'h0106);

    // Sequence of 9 beats with seq_start on the first
    in_valid = 1'b1; mode = 1'b1; seq_start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      seq_start = 1'b0;
      chk_beat($sformatf("seq%0d", k), k % 7, (k % 7) == 6);
    end

    // Backpressure: output holds idx 1, counter sits at 2
    out_ready = 1'b0;
    #1;
    chk("bp_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_beat($sformatf("bp%0d", k), 1, 1'b0);
      chk($sformatf("bp%0d_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 32'd1);
    step();
    chk_beat("bp_resume", 2, 1'b0);

    // seq_start coinciding with an accept at count 4
    step();
    chk_beat("pre_restart", 3, 1'b0);
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    chk_beat("restart", 0, 1'b0);
    step();
    chk_beat("after_restart", 1, 1'b0);
    in_valid = 1'b0;
    step();
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    in_valid = 1'b1;
    step();
    chk_beat("idle_restart", 0, 1'b0);

    // Out-of-range direct select
    mode = 1'b0; sel = 3'd7;
    step();
    chk_beat("oor", 7, 1'b0);
    in_valid = 1'b0;
`ifdef NTT_MUX_SEL_ERR_EN
    chk("err_set", 32'(sel_err), 32'd1);
    step();
    step();
    chk("err_sticky", 32'(sel_err), 32'd1);
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    chk("err_clear", 32'(sel_err), 32'd0);
`else
    step();
`endif

    // Async reset mid-sequence
    in_valid = 1'b1; mode = 1'b1; seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    step();
    chk_beat("pre_rst", 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_idx",   32'(out_idx),   32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_beat("post_rst", 0, 1'b0);
    step();
    chk_beat("post_rst2", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
